// File: rtl/encoder_mxn_serial_pkg.sv
// Shared types for the serial multi-hot to binary-index encoder.
// Holds the two-state FSM encoding used by the top level.
// No logic; imported by the interface-facing modules.
package encoder_mxn_serial_pkg;

    // IDLE accepts a vector, DRAIN emits one index per transfer.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } enc_state_t;

endpackage

// File: rtl/encoder_mxn_serial_if.sv
// Request/index handshake bundle for encoder_mxn_serial.
// Request side: in/in_valid/in_ready. Index side: out/out_valid/out_ready/out_last,
// plus count (popcount of last accepted vector) and zero_err (all-zero accept pulse).
interface encoder_mxn_serial_if #(
    parameter int N = 4,
    parameter int M = 1 << N
);
    logic [M-1:0] in;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [N:0]   count;
    logic         zero_err;

    // Driver of requests and consumer of indices.
    modport master (
        output in, in_valid, out_ready,
        input  in_ready, out, out_valid, out_last, count, zero_err
    );

    // The encoder itself.
    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, out, out_valid, out_last, count, zero_err
    );
endinterface

// File: rtl/encoder_mxn_serial_lsb.sv
// Lowest-set-bit priority encoder, purely combinational (zero latency).
// Ports: pending[M-1:0] in; idx[N-1:0], any out. pending==0 gives idx=0, any=0.
// No handshake; the caller decides when the result is consumed.
module lsb_priority_enc #(
    parameter int N = 4,
    parameter int M = 1 << N
) (
    input  logic [M-1:0] pending,
    output logic [N-1:0] idx,
    output logic         any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        // Scan from the top down so the lowest set bit is the last write.
        for (int i = M - 1; i >= 0; i--) begin
            if (pending[i]) begin
                idx = i[N-1:0];
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/encoder_mxn_serial.sv
// Serial encoder: accepts an M-bit multi-hot vector, emits each set bit's index, lowest first.
// Ports: clk, rst_n (sync, active low), bus (slave modport of encoder_mxn_serial_if).
// Latency: accept at edge k -> first index valid in cycle k+1; in_ready low while draining,
// indices hold stable while out_ready is low; one bubble cycle between vectors.
module encoder_mxn_serial
    import encoder_mxn_serial_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 1 << N
) (
    input  logic                      clk,
    input  logic                      rst_n,
    encoder_mxn_serial_if.slave       bus
);
    enc_state_t   state;
    logic [M-1:0] pending;
    logic [N:0]   count_q;
    logic         zero_err_q;

    logic [N-1:0] low_idx;
    logic         low_any;
    logic [N:0]   pop;
    logic         single;

    lsb_priority_enc #(.N(N), .M(M)) u_lsb (
        .pending (pending),
        .idx     (low_idx),
        .any     (low_any)
    );

    // Popcount of the incoming vector; only registered on accept.
    always_comb begin
        pop = '0;
        for (int i = 0; i < M; i++) begin
            pop = pop + {{N{1'b0}}, bus.in[i]};
        end
    end

    // Exactly one bit left: clearing the lowest bit leaves nothing.
    assign single = low_any && ((pending & (pending - 1'b1)) == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pending    <= '0;
            count_q    <= '0;
            zero_err_q <= 1'b0;
        end else begin
            zero_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.in != '0) begin
                            pending <= bus.in;
                            count_q <= pop;
                            state   <= ST_DRAIN;
                        end else begin
                            count_q    <= '0;
                            zero_err_q <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.out_ready) begin
                        // Drop the index just transferred.
                        pending <= pending & (pending - 1'b1);
                        if (single) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DRAIN);
    assign bus.out       = low_idx;
    assign bus.out_last  = single;
    assign bus.count     = count_q;
    assign bus.zero_err  = zero_err_q;
endmodule

// File: tb/tb_encoder_mxn_serial.sv
module tb_encoder_mxn_serial;
    localparam int N = 4;
    localparam int M = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    encoder_mxn_serial_if #(.N(N), .M(M)) bus ();

    encoder_mxn_serial #(.N(N), .M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All drives and samples happen 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [M-1:0] v);
        bus.in       = v;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in       = '0;
    endtask

    // Drain with out_ready held high; expected indices come from scanning the vector.
    task automatic drain_full(input string name, input logic [M-1:0] v, input int exp_cnt);
        logic [M-1:0] seen;
        int           n;
        seen = '0;
        n    = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < M; i++) begin
            if (v[i]) begin
                n++;
                check({name, " valid"}, {31'b0, bus.out_valid}, 32'd1);
                check({name, " idx"}, {28'b0, bus.out}, i);
                check({name, " last"}, {31'b0, bus.out_last}, {31'b0, (n == exp_cnt)});
                seen = seen | (16'd1 << bus.out);
                step();
            end
        end
        bus.out_ready = 1'b0;
        check({name, " count"}, {27'b0, bus.count}, exp_cnt);
        check({name, " roundtrip"}, {16'b0, seen}, {16'b0, v});
        check({name, " ready after"}, {31'b0, bus.in_ready}, 32'd1);
    endtask

    typedef struct {
        string        name;
        logic [M-1:0] vec;
        int           exp_cnt;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{"single_msb", 16'h8000, 1};
        tbl[1] = '{"multi",      16'h0491, 4};
        tbl[2] = '{"full",       16'hFFFF, 16};
        tbl[3] = '{"lsb",        16'h0001, 1};
        tbl[4] = '{"pattern",    16'hA5A5, 8};
        tbl[5] = '{"pair",       16'h0180, 2};

        bus.in        = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset in_ready",  {31'b0, bus.in_ready},  32'd1);
        check("reset count",     {27'b0, bus.count},     32'd0);
        check("reset zero_err",  {31'b0, bus.zero_err},  32'd0);

        // Table-driven vectors.
        for (int t = 0; t < 6; t++) begin
            accept(tbl[t].vec);
            check({tbl[t].name, " busy"}, {31'b0, bus.in_ready}, 32'd0);
            drain_full(tbl[t].name, tbl[t].vec, tbl[t].exp_cnt);
        end

        // Single bit: ready returns two cycles after accept.
        accept(16'h8000);
        bus.out_ready = 1'b1;
        check("single idx",  {28'b0, bus.out},      32'd15);
        check("single last", {31'b0, bus.out_last}, 32'd1);
        check("single cnt",  {27'b0, bus.count},    32'd1);
        step();
        bus.out_ready = 1'b0;
        check("single in_ready", {31'b0, bus.in_ready},  32'd1);
        check("single idle",     {31'b0, bus.out_valid}, 32'd0);

        // Multi-hot with stalls: ready 1,0,1,0,1,1 -> out 0,4,4,7,7,10.
        begin
            logic [5:0] rdy_pat [6];
            int         exp_out [6];
            rdy_pat = '{1, 0, 1, 0, 1, 1};
            exp_out = '{0, 4, 4, 7, 7, 10};
            accept(16'h0491);
            for (int c = 0; c < 6; c++) begin
                bus.out_ready = rdy_pat[c][0];
                check("stall valid", {31'b0, bus.out_valid}, 32'd1);
                check("stall idx",   {28'b0, bus.out},       exp_out[c]);
                check("stall last",  {31'b0, bus.out_last},  {31'b0, (c == 5)});
                step();
            end
            bus.out_ready = 1'b0;
            check("stall count", {27'b0, bus.count},    32'd4);
            check("stall done",  {31'b0, bus.in_ready}, 32'd1);
        end

        // Zero vector: one-cycle error pulse, no drain, count cleared.
        accept(16'h0000);
        check("zero err",      {31'b0, bus.zero_err},  32'd1);
        check("zero valid",    {31'b0, bus.out_valid}, 32'd0);
        check("zero in_ready", {31'b0, bus.in_ready},  32'd1);
        check("zero count",    {27'b0, bus.count},     32'd0);
        step();
        check("zero pulse end", {31'b0, bus.zero_err},  32'd0);
        check("zero still idle", {31'b0, bus.out_valid}, 32'd0);

        // Reset mid-drain discards remaining indices.
        accept(16'hFFFF);
        check("rst cnt16", {27'b0, bus.count}, 32'd16);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("rst pre idx", {28'b0, bus.out}, c);
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        check("rst out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst in_ready",  {31'b0, bus.in_ready},  32'd1);
        check("rst count",     {27'b0, bus.count},     32'd0);
        accept(16'h0002);
        drain_full("post_rst", 16'h0002, 1);
        check("post_rst idle", {31'b0, bus.out_valid}, 32'd0);

        // Input changes and in_valid pulses while draining are ignored.
        accept(16'h0C30);
        bus.in       = 16'hFFFF;
        bus.in_valid = 1'b1;
        begin
            logic [M-1:0] seen;
            int           exp_seq [4];
            exp_seq = '{4, 5, 10, 11};
            seen = '0;
            bus.out_ready = 1'b1;
            for (int c = 0; c < 4; c++) begin
                check("busy idx", {28'b0, bus.out}, exp_seq[c]);
                seen = seen | (16'd1 << bus.out);
                if (c == 3) bus.in_valid = 1'b0;
                step();
            end
            bus.out_ready = 1'b0;
            bus.in        = '0;
            check("busy roundtrip", {16'b0, seen}, 32'h0C30);
            check("busy count",     {27'b0, bus.count}, 32'd4);
            check("busy idle",      {31'b0, bus.out_valid}, 32'd0);
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
